ripple_borrow_subtractor_seq: RTL



---
 rtl/rca_pkg.sv | 17 +
 rtl/full_subtractor.sv | 15 +
 rtl/ripple_borrow_subtractor_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared types and sizing helpers for the ripple adder/subtractor family.
// Chunked variants size their slice counters from n_chunks().
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int CHUNK_DEFAULT = 8;

    function automatic int n_chunks(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - borrow_in.
// Borrows out when b plus the incoming borrow exceeds a.
module full_subtractor (
    input  logic i_bit1,
    input  logic i_bit2,
    input  logic i_borrow,
    output logic o_diff,
    output logic o_borrow
);

    assign o_diff   = i_bit1 ^ i_bit2 ^ i_borrow;
    assign o_borrow = (~i_bit1 & i_bit2)
                    | (~(i_bit1 ^ i_bit2) & i_borrow);

endmodule

// File: rtl/ripple_borrow_subtractor_seq.sv
// Multi-cycle ripple-borrow subtractor, CHUNK bits per RUN cycle.
// Result is {borrow, difference} with valid/ready on both sides.
module ripple_borrow_subtractor_seq
    import rca_pkg::*;
#(
    parameter int WIDTH = 61,
    parameter int CHUNK = CHUNK_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_sub_term1,
    input  logic [WIDTH-1:0] i_sub_term2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result
);

    localparam int N_CHUNKS = n_chunks(WIDTH, CHUNK);
    localparam int PW       = N_CHUNKS * CHUNK;
    localparam int LAST_W   = WIDTH - (N_CHUNKS - 1) * CHUNK;
    localparam int IDXW     = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int BW       = $clog2(PW) + 1;

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_CHUNKS - 1);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              borrow_q, borrow_d;
    logic [PW-1:0]     t1_q, t1_d;
    logic [PW-1:0]     t2_q, t2_d;
    logic [WIDTH-1:0]  diff_q, diff_d;

    logic [BW-1:0]     base;
    logic [CHUNK-1:0]  s1, s2, sdiff;
    logic [CHUNK:0]    bchain;

    assign base      = BW'(idx_q) * BW'(CHUNK);
    assign s1        = t1_q[base +: CHUNK];
    assign s2        = t2_q[base +: CHUNK];
    assign bchain[0] = borrow_q;

    for (genvar g = 0; g < CHUNK; g++) begin : g_fs
        full_subtractor u_fs (
            .i_bit1   (s1[g]),
            .i_bit2   (s2[g]),
            .i_borrow (bchain[g]),
            .o_diff   (sdiff[g]),
            .o_borrow (bchain[g+1])
        );
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        t1_d     = t1_q;
        t2_d     = t2_q;
        diff_d   = diff_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    t1_d     = PW'(i_sub_term1);
                    t2_d     = PW'(i_sub_term2);
                    borrow_d = 1'b0;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // padding columns of the last slice are never stored
                for (int i = 0; i < CHUNK; i++) begin
                    if (int'(base) + i < WIDTH) begin
                        diff_d[int'(base)+i] = sdiff[i];
                    end
                end
                if (idx_q == IDX_LAST) begin
                    borrow_d = bchain[LAST_W];
                    idx_d    = '0;
                    state_d  = DONE;
                end else begin
                    borrow_d = bchain[CHUNK];
                    idx_d    = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            t1_q     <= '0;
            t2_q     <= '0;
            diff_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            t1_q     <= t1_d;
            t2_q     <= t2_d;
            diff_q   <= diff_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_result = {borrow_q, diff_q};

endmodule
